// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT receive path: FSM encoding, defaults, parity helper.
package usrt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int   DEF_DATA_BITS = 8;
  localparam logic LINE_IDLE     = 1'b1;

  // Returns 1 when the received parity bit disagrees with the configured sense.
  function automatic logic calc_parity_err(logic [7:0] data, logic pbit, logic odd);
    return ^data ^ pbit ^ odd;
  endfunction

endpackage

// File: rtl/usrt_sync.sv
// N-stage flip-flop synchronizer with a configurable reset level.
module usrt_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the chain; presetting avoids a false edge at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value in the same edge.
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/usrt_rx_shift.sv
// USRT receive deserializer: samples Rxd on synchronized Sclk rising edges, strips
// start/parity/stop and hands each byte to the data register with a one-cycle strobe.
module usrt_rx_shift
  import usrt_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter bit PARITY_EN   = 1'b1,
  parameter bit PARITY_ODD  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Pclk,
  input  logic       i_Rst_n,
  input  logic       i_Rx_En,
  input  logic       i_Sclk,
  input  logic       i_Rxd,
  output logic [7:0] o_Data,
  output logic       o_Enable,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int               CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic                 sclk_s, rxd_s, sclk_prev, sclk_rise;
  rx_state_e            state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 pbit_q, pbit_nxt;
  logic                 commit, frame_hit, perr;

  usrt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(LINE_IDLE)) u_sync_sclk (
    .clk   (i_Pclk),
    .rst_n (i_Rst_n),
    .d     (i_Sclk),
    .q     (sclk_s)
  );

  usrt_sync #(.STAGES(SYNC_STAGES), .RST_VAL(LINE_IDLE)) u_sync_rxd (
    .clk   (i_Pclk),
    .rst_n (i_Rst_n),
    .d     (i_Rxd),
    .q     (rxd_s)
  );

  assign sclk_rise = sclk_s & ~sclk_prev;

  // Frame progress only advances on serial-clock rising edges; disable overrides everything.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    shift_nxt = shift_q;
    pbit_nxt  = pbit_q;
    commit    = 1'b0;
    frame_hit = 1'b0;
    if (!i_Rx_En) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (sclk_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
            shift_nxt = '0;
            pbit_nxt  = 1'b0;
          end
        end
        ST_DATA: begin
          shift_nxt[cnt_q] = rxd_s;
          if (cnt_q == LAST_BIT) begin
            state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          pbit_nxt  = rxd_s;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (rxd_s) begin
            commit    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_hit = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rxd_s) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign perr = PARITY_EN ? calc_parity_err(8'(shift_q), pbit_q, PARITY_ODD) : 1'b0;

  // State, counter, shifter and Sclk history registers.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      sclk_prev <= LINE_IDLE;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      shift_q   <= shift_nxt;
      pbit_q    <= pbit_nxt;
      sclk_prev <= sclk_s;
    end
  end

  // Registered outputs: strobes appear the cycle after the stop-bit edge is seen.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Data       <= '0;
      o_Enable     <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      o_Enable     <= commit;
      o_Parity_Err <= commit & perr;
      o_Frame_Err  <= frame_hit;
      if (commit) o_Data <= 8'(shift_q);
    end
  end

  assign o_Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usrt_rx_shift.sv
// Directed bench for usrt_rx_shift: 100 ns Pclk, 1 us Sclk, Rxd changed on Sclk falling edge.
module tb_usrt_rx_shift;

  logic       i_Pclk, i_Rst_n, i_Rx_En, i_Sclk, i_Rxd;
  logic [7:0] o_Data;
  logic       o_Enable, o_Parity_Err, o_Frame_Err, o_Busy;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state, written only by the monitor process.
  int         strobes  = 0;
  int         perr_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] data_log[$];

  usrt_rx_shift dut (
    .i_Pclk       (i_Pclk),
    .i_Rst_n      (i_Rst_n),
    .i_Rx_En      (i_Rx_En),
    .i_Sclk       (i_Sclk),
    .i_Rxd        (i_Rxd),
    .o_Data       (o_Data),
    .o_Enable     (o_Enable),
    .o_Parity_Err (o_Parity_Err),
    .o_Frame_Err  (o_Frame_Err),
    .o_Busy       (o_Busy)
  );

  initial i_Pclk = 1'b0;
  always #50 i_Pclk = ~i_Pclk;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge i_Pclk) begin
    if (o_Enable) begin
      strobes <= strobes + 1;
      data_log.push_back(o_Data);
      if (o_Parity_Err) perr_cnt <= perr_cnt + 1;
    end
    if (o_Frame_Err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One serial bit: Rxd changes with Sclk falling, sampled at Sclk rising.
  task automatic sclk_bit(input logic b);
    i_Sclk = 1'b0;
    i_Rxd  = b;
    #500;
    i_Sclk = 1'b1;
    #500;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) sclk_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    sclk_bit(1'b0);
    for (int i = 0; i < 8; i++) sclk_bit(d[i]);
    sclk_bit(pbit);
    sclk_bit(stop);
  endtask

  int         s0, p0, f0, n0;
  logic [7:0] partial;

  initial begin
    i_Rst_n = 1'b0;
    i_Rx_En = 1'b1;
    i_Sclk  = 1'b1;
    i_Rxd   = 1'b1;
    #250;
    check("rst_data",   32'(o_Data), 32'h00);
    check("rst_enable", 32'(o_Enable), 32'd0);
    check("rst_perr",   32'(o_Parity_Err), 32'd0);
    check("rst_ferr",   32'(o_Frame_Err), 32'd0);
    check("rst_busy",   32'(o_Busy), 32'd0);
    #50;
    i_Rst_n = 1'b1;
    idle_bits(2);

    // 1: good even-parity frame 0xE2 (parity bit 0)
    s0 = strobes; p0 = perr_cnt; f0 = ferr_cnt;
    sclk_bit(1'b0);
    sclk_bit(1'b0);
    check("t1_busy_mid", 32'(o_Busy), 32'd1);
    for (int i = 1; i < 8; i++) sclk_bit(1'(8'hE2 >> i));
    sclk_bit(1'b0);
    sclk_bit(1'b1);
    idle_bits(2);
    check("t1_strobes", 32'(strobes - s0), 32'd1);
    check("t1_data",    32'(o_Data), 32'hE2);
    check("t1_perr",    32'(perr_cnt - p0), 32'd0);
    check("t1_ferr",    32'(ferr_cnt - f0), 32'd0);
    check("t1_idle",    32'(o_Busy), 32'd0);

    // 2: 0x2E with wrong parity bit 1
    s0 = strobes; p0 = perr_cnt;
    send_frame(8'h2E, 1'b1, 1'b1);
    idle_bits(2);
    check("t2_strobes", 32'(strobes - s0), 32'd1);
    check("t2_data",    32'(o_Data), 32'h2E);
    check("t2_perr",    32'(perr_cnt - p0), 32'd1);

    // 3: 0xA5 with stop bit 0, then line idle, then 0x3C
    s0 = strobes; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("t3_busy_break", 32'(o_Busy), 32'd1);
    idle_bits(2);
    check("t3_ferr",    32'(ferr_cnt - f0), 32'd1);
    check("t3_strobes", 32'(strobes - s0), 32'd0);
    check("t3_hold",    32'(o_Data), 32'h2E);
    check("t3_o_ferr_low", 32'(o_Frame_Err), 32'd0);
    s0 = strobes; p0 = perr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("t3_next_strobes", 32'(strobes - s0), 32'd1);
    check("t3_next_data",    32'(o_Data), 32'h3C);
    check("t3_next_perr",    32'(perr_cnt - p0), 32'd0);

    // 4: 0x01 then 0xFF back-to-back
    s0 = strobes; p0 = perr_cnt; f0 = ferr_cnt; n0 = data_log.size();
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(2);
    check("t4_strobes", 32'(strobes - s0), 32'd2);
    check("t4_first",   32'(data_log[n0]), 32'h01);
    check("t4_second",  32'(data_log[n0+1]), 32'hFF);
    check("t4_perr",    32'(perr_cnt - p0), 32'd0);
    check("t4_ferr",    32'(ferr_cnt - f0), 32'd0);

    // 5: disable after 4 data bits of 0x55, re-enable, send 0x77
    s0 = strobes;
    partial = 8'h55;
    sclk_bit(1'b0);
    for (int i = 0; i < 4; i++) sclk_bit(partial[i]);
    i_Rx_En = 1'b0;
    idle_bits(2);
    check("t5_busy_dis", 32'(o_Busy), 32'd0);
    check("t5_hold",     32'(o_Data), 32'hFF);
    i_Rx_En = 1'b1;
    idle_bits(1);
    send_frame(8'h77, 1'b0, 1'b1);
    idle_bits(2);
    check("t5_strobes", 32'(strobes - s0), 32'd1);
    check("t5_data",    32'(o_Data), 32'h77);

    // 6: reset mid-frame, then 0x81
    sclk_bit(1'b0);
    sclk_bit(1'b1);
    sclk_bit(1'b0);
    check("t6_busy_pre", 32'(o_Busy), 32'd1);
    #130;
    i_Rst_n = 1'b0;
    #40;
    check("t6_rst_data", 32'(o_Data), 32'h00);
    check("t6_rst_busy", 32'(o_Busy), 32'd0);
    check("t6_rst_en",   32'(o_Enable), 32'd0);
    #230;
    i_Rst_n = 1'b1;
    #600;
    idle_bits(2);
    s0 = strobes; p0 = perr_cnt;
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);
    check("t6_strobes", 32'(strobes - s0), 32'd1);
    check("t6_data",    32'(o_Data), 32'h81);
    check("t6_perr",    32'(perr_cnt - p0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
